multicycle_controller: RTL
==========================

# multicycle_controller

Control unit for the multi-cycle RISC-V core: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back over several clocks, sharing one ALU and one unified memory. It supersedes the single-cycle controller. It adds:
- a variable-latency memory handshake;
- bne/blt/bge, jalr and lui support;
- a sticky illegal-instruction halt.

It drives the multi-cycle datapath's muxes and enables. It stores no data.

## Interface
- `MEM_HANDSHAKE`, default 1: when 0, `mem_ready` is ignored and treated as 1.
- `ALU_CTRL_W`, default 3: width of `ALUControl`.

- `clk` in 1: single clock. Rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `op` in 7: opcode from the instruction register.
- `func3` in 3: instruction funct3.
- `func7` in 7: instruction funct7. Only bit 5 is used.
- `zero`, `neg` in 1 each: ALU flags of the current cycle.
- `mem_ready` in 1: memory access completes this cycle.
- `mem_req` out 1: memory access request.
- `MemWrite` out 1: the request is a store.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = Result.
- `IRWrite` out 1: latch instruction and OldPC.
- `PCWrite` out 1: load PC from Result.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: 00 = rs2, 01 = imm, 10 = 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = imm.
- `ImmSrc` out 3: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `ALUControl` out `ALU_CTRL_W`: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `illegal` out 1: sticky; the controller is halted.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, HALT.
- FETCH
  - Asserts `mem_req`, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, add, `ResultSrc`=10.
  - Asserts `IRWrite` and `PCWrite` only in the cycle `mem_ready`=1. Stays in FETCH otherwise.
- DECODE
  - Computes `ALUSrcA`=01, `ALUSrcB`=01, add. ALUOut receives the branch/jal target.
  - `ImmSrc` is set from `op`.
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - anything else → HALT
- MEMADR: computes rs1 + imm. Goes to MEMRD for a load, MEMWR for a store.
- MEMRD: `mem_req`, `AdrSrc`=1. Waits on `mem_ready`, then MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`. Then FETCH.
- MEMWR: `mem_req`, `MemWrite`, `AdrSrc`=1. Waits on `mem_ready`, then FETCH.
- EXECR and EXECI: the ALU function comes from the ALU decode rules below. Then ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`. Then FETCH.
- BRANCH
  - Computes rs1 − rs2 with `ResultSrc`=00.
  - `PCWrite` = taken. Taken is:
    - func3 000: `zero`
    - func3 001: !`zero`
    - func3 100: `neg`
    - func3 101: !`neg`
  - Other func3 values → HALT, with no `PCWrite`.
  - Otherwise next state is FETCH.
- JAL: `PCWrite` with `ResultSrc`=00. The ALU concurrently computes OldPC + 4. Then ALUWB.
- JALR: rs1 + imm, `ResultSrc`=10, `PCWrite`. Then LINK.
- LINK: OldPC + 4. Then ALUWB.
- LUI: `ImmSrc`=100, `ResultSrc`=11, `RegWrite`. Then FETCH.
- HALT: all enables 0, `illegal`=1. Leaves only on reset.
- ALU decode:

  | ALUOp | func3 | Condition | `ALUControl` |
  |---|---|---|---|
  | add | – | – | 000 |
  | sub | – | – | 001 |
  | funct | 000 | R-type with func7[5]=1 | sub (001) |
  | funct | 000 | otherwise | add (000) |
  | funct | 010 | – | slt (101) |
  | funct | 110 | – | or (011) |
  | funct | 111 | – | and (010) |

  Any other func3 in EXECR or EXECI → HALT.

## Timing
- Reset (`rst_n`=0): asynchronous.
  - State becomes FETCH.
  - `illegal` becomes 0.
  - While reset is low, every output is held at 0.
- Reset asserted mid-instruction aborts the instruction. No enable is asserted afterward.
- All outputs are decoded from the state plus `op`, `func3`, `func7`, `zero`, `neg` and `mem_ready`. There are no registered outputs other than the state and `illegal`.
- Cycle counts with zero wait states:

  | Instruction | Cycles |
  |---|---|
  | R-type, I-type ALU | 4 |
  | lw | 5 |
  | sw | 4 |
  | branch | 3 |
  | lui | 3 |
  | jal | 4 |
  | jalr | 5 |

  Each memory wait cycle adds exactly 1 cycle.
- `mem_req`, `AdrSrc` and `MemWrite` are held stable while waiting. `IRWrite`, `PCWrite` and `RegWrite` fire exactly once per instruction.

## Structure
- Shared package `multicycle_pkg`:
  - state enum
  - opcode constants
  - `ImmSrc`, `ALUSrcA`, `ALUSrcB`, `ResultSrc`, `ALUControl` and `ALUOp` encodings
- Sub-module `alu_op_decoder`: combinational. Inputs ALUOp, func3, func7[5], op[5]. Outputs `ALUControl` and a bad-func3 flag.

## Test plan
- add x3,x1,x2 (0x002081B3), `mem_ready`=1 → FETCH/DECODE/EXECR/ALUWB, then FETCH. `ALUControl`=000. One `RegWrite` in cycle 4.
- lw with `mem_ready` held low 3 cycles in MEMRD → 8 total cycles. `mem_req`/`AdrSrc`=1 stable throughout. `RegWrite` with `ResultSrc`=01 once.
- beq and bne, each with `zero`=1 and `zero`=0:
  - beq with `zero`=1 asserts `PCWrite` in cycle 3.
  - bne with `zero`=1 does not.
  - blt with `neg`=1 asserts `PCWrite`.
- jalr → JALR (`PCWrite`, `ResultSrc`=10), then LINK (`ALUSrcA`=01, `ALUSrcB`=10), then ALUWB `RegWrite`. 5 cycles.
- Opcode 0000000 → HALT, `illegal`=1, all enables 0 for 20 cycles. `rst_n` pulse → FETCH, `illegal`=0.
- `rst_n` dropped during MEMWR wait → outputs 0 immediately. After release, FETCH with `mem_req`=1 and `MemWrite`=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and encodings for the multi-cycle controller
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LINK,
    S_LUI,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    logic [2:0] imm;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      OP_LUI:    imm = IMM_U;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

  // Returns {supported, taken}; unsupported branch kinds halt the core.
  function automatic logic [1:0] branch_eval(input logic [2:0] func3,
                                             input logic zero,
                                             input logic neg);
    logic [1:0] r;
    case (func3)
      3'b000:  r = {1'b1, zero};
      3'b001:  r = {1'b1, !zero};
      3'b100:  r = {1'b1, neg};
      3'b101:  r = {1'b1, !neg};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bus between controller and datapath
interface multicycle_controller_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [6:0]            op;
  logic [2:0]            func3;
  logic [6:0]            func7;
  logic                  zero;
  logic                  neg;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  MemWrite;
  logic                  AdrSrc;
  logic                  IRWrite;
  logic                  PCWrite;
  logic                  RegWrite;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ResultSrc;
  logic [2:0]            ImmSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic                  illegal;

  modport master (
    input  op, func3, func7, zero, neg, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal
  );

  modport slave (
    output op, func3, func7, zero, neg, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal
  );
endinterface

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - maps ALUOp/funct fields to an ALU function
module alu_op_decoder
  import multicycle_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       op_5,
  output logic [2:0] alu_control,
  output logic       bad_func3
);

  always_comb begin
    alu_control = ALU_ADD;
    bad_func3   = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (func3)
          // Only R-type (op[5]=1) uses funct7 to select sub; addi ignores it.
          3'b000:  alu_control = (func7_5 && op_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: bad_func3 = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RISC-V control FSM with memory handshake
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ALU_CTRL_W    = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);

  state_t     state;
  state_t     state_next;
  logic       illegal_q;
  logic       ready;
  alu_op_t    alu_op;
  logic [2:0] alu_ctrl;
  logic       bad_func3;
  logic [1:0] br;

  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] imm_src;

  assign ready = !MEM_HANDSHAKE || bus.mem_ready;
  assign br    = branch_eval(bus.func3, bus.zero, bus.neg);

  alu_op_decoder u_alu_op_decoder (
    .alu_op      (alu_op),
    .func3       (bus.func3),
    .func7_5     (bus.func7[5]),
    .op_5        (bus.op[5]),
    .alu_control (alu_ctrl),
    .bad_func3   (bad_func3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_HALT) begin
        illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    alu_op     = ALUOP_ADD;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;

    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures OldPC + imm so BRANCH/JAL find their target ready.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_src_for(bus.op);
        case (bus.op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = imm_src_for(bus.op);
        state_next = (bus.op == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready) begin
          state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (ready) begin
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = bad_func3 ? S_HALT : S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        alu_op     = ALUOP_FUNCT;
        state_next = bad_func3 ? S_HALT : S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        imm_src    = IMM_B;
        result_src = RES_ALUOUT;
        if (br[1]) begin
          pc_write   = br[0];
          state_next = S_FETCH;
        end else begin
          state_next = S_HALT;
        end
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        imm_src    = IMM_J;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_next = S_LINK;
      end
      S_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  // Reset forces FETCH, but nothing may be driven until reset is released.
  assign bus.mem_req    = rst_n & mem_req;
  assign bus.MemWrite   = rst_n & mem_write;
  assign bus.AdrSrc     = rst_n & adr_src;
  assign bus.IRWrite    = rst_n & ir_write;
  assign bus.PCWrite    = rst_n & pc_write;
  assign bus.RegWrite   = rst_n & reg_write;
  assign bus.ALUSrcA    = rst_n ? alu_src_a : 2'b00;
  assign bus.ALUSrcB    = rst_n ? alu_src_b : 2'b00;
  assign bus.ResultSrc  = rst_n ? result_src : 2'b00;
  assign bus.ImmSrc     = rst_n ? imm_src : 3'b000;
  assign bus.ALUControl = rst_n ? ALU_CTRL_W'(alu_ctrl) : '0;
  assign bus.illegal    = rst_n & illegal_q;

endmodule
